safe_cpu_reg_obi_responder: RTL
===============================

Name: safe_cpu_reg_obi_responder

Overview:
- OBI responder that terminates the system-crossbar slave port for the safe-CPU register window: SAFE_CPU_REGISTER_IDX, base GLOBAL_BASE_ADDRESS+0x12000, 0x100 bytes.
- Decodes word offsets, executes reads and writes on a small register bank, and returns ordered responses through a 2-entry response buffer.
- Supports the optional OBI rready back-pressure signal.
- Exports control registers and a status/IRQ line to the safe-CPU control logic.

Parameters:
- NUM_REGS, 16, number of 32-bit words implemented (valid range 3..64).
- RSP_DEPTH, 2, response buffer entries (minimum 1).
- ID_VALUE, 32'h5AFE0001, read-only identification word at offset 0x0.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- req_i  in  1  OBI request
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  32  byte address. Window-aligned; only addr_i[7:0] is decoded.
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rready_i  in  1  response accept. Tie high for plain OBI.
- rdata_o  out  32  read data
- err_o  out  1  error response
- hw_set_i  in  32  per-bit set pulses into STATUS
- ctrl_o  out  32*(NUM_REGS-2)  contents of words 2..NUM_REGS-1
- irq_o  out  1  OR-reduction of STATUS

Behaviour:
- Register map:
  - word 0 = ID, RO.
  - word 1 = STATUS, W1C plus hardware set.
  - words 2..NUM_REGS-1 = RW control registers.
- gnt_o = req_i & ~full.
  - Purely combinational from req_i and the buffer count; no rready_i→gnt_o path.
  - gnt_o is 0 while rst_ni is low.
- Access takes effect at the granting clock edge.
  - A read returns the register value present in the grant cycle, before any update at that edge.
- Error conditions. Any of the following gives err=1 and rdata=32'hBADACCE5, with no state change:
  - addr_i[1:0] != 0
  - word offset addr_i[7:2] >= NUM_REGS
  - write to ID
- Successful write: err=0, rdata=0.
- be_i=0 write: succeeds with no change.
- RW write: each byte i with be_i[i]=1 is replaced by wdata_i byte i.
- STATUS next-state = (status & ~clr) | hw_set_i.
  - clr = wdata_i masked by be_i bytes on a granted STATUS write, else 0.
  - Set wins over a simultaneous clear.
- Response buffer is a FIFO of {err, rdata}.
  - Push on grant; pop on rvalid_o & rready_i.
  - Push and pop in the same cycle keep the count unchanged.
- rvalid_o = ~empty. Minimum latency is 1 cycle: rvalid_o rises in the cycle after gnt_o.
- Responses are strictly in grant order.
- rdata_o and err_o are 0 when rvalid_o = 0.
- When full, further requests wait (gnt_o = 0); req_i and the address are held by the initiator per OBI.
- Count wrap is impossible: full blocks push, and empty-pop is ignored.
- Reset values:
  - all registers 0
  - FIFO empty; rvalid_o, rdata_o, err_o = 0
  - ctrl_o = 0, irq_o = 0
- Reset asserted mid-operation flushes buffered responses immediately (asynchronously). Pending responses are lost; the initiator is reset in the same domain.
- irq_o is registered (|status_q) and is high the cycle after a set.

Decomposition:
- cei_mochila_pkg gains:
  - SAFE_REG_ID_OFFSET = 0
  - SAFE_REG_STATUS_OFFSET = 1
  - SAFE_REG_CTRL_BASE = 2
  - SAFE_REG_ID_VALUE
  - ERR_RDATA = 32'hBADACCE5 (shared with ERROR_START_ADDRESS usage)
  - packed typedef safe_reg_rsp_t {logic err; logic [31:0] rdata;}
- One sub-module: obi_rsp_fifo.
  - Parameterised depth/type; push/pop/full/empty.
  - Reusable by other crossbar responders.

Test Plan:
- ID read after reset: req addr 0xF0012000, we=0 → gnt_o same cycle; next cycle rvalid_o=1, rdata_o=0x5AFE0001, err_o=0.
- Partial write: word 2 (0xF0012008), wdata 0xDEADBEEF, be=0011 → ctrl_o[31:0]=0x0000BEEF. Readback returns 0x0000BEEF; back-to-back write→read of the same word returns the new value.
- Back-pressure: rready_i=0 and three consecutive reads → two grants, third gnt_o=0. A one-cycle rready_i pulse pops the first response and grants the third; responses arrive in order.
- STATUS race: hw_set_i=0x8 in the same cycle as a W1C write of 0x8 → STATUS=0x8, irq_o=1. A later W1C of 0x8 with hw_set_i=0 → STATUS=0, irq_o=0 the following cycle.
- Errors: each of the following → err_o=1, rdata_o=0xBADACCE5, all registers unchanged:
  - addr 0xF0012040 with NUM_REGS=16
  - addr 0xF0012002
  - write to 0xF0012000
- Async reset mid-operation: two responses buffered, rst_ni low between edges → rvalid_o, ctrl_o, irq_o are 0 before the next clock edge. After release, an ID read behaves as in the first scenario.

Source files
------------

// File: rtl/cei_mochila_pkg.sv
// Shared constants and types for the safe-CPU register window responder.
package cei_mochila_pkg;

  localparam logic [31:0] GLOBAL_BASE_ADDRESS       = 32'hF000_0000;
  localparam logic [31:0] SAFE_CPU_REG_START_ADDRESS = GLOBAL_BASE_ADDRESS + 32'h0001_2000;
  localparam logic [31:0] SAFE_CPU_REG_SIZE          = 32'h0000_0100;

  // Word offsets inside the window
  localparam int unsigned SAFE_REG_ID_OFFSET     = 0;
  localparam int unsigned SAFE_REG_STATUS_OFFSET = 1;
  localparam int unsigned SAFE_REG_CTRL_BASE     = 2;

  localparam logic [31:0] SAFE_REG_ID_VALUE = 32'h5AFE_0001;

  // Read data returned with every error response
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } safe_reg_rsp_t;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Small in-order response FIFO for OBI responders; push is ignored when full,
// pop is ignored when empty.
module obi_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Status flags and guarded handshakes
  always_comb begin
    full_o  = (count_q == DepthCnt);
    empty_o = (count_q == '0);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    data_o  = mem_q[rptr_q];
  end

  // Pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while non-empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/safe_cpu_reg_obi_responder.sv
// OBI responder for the safe-CPU register window: ID, W1C STATUS with hardware
// set, and RW control words, with ordered buffered responses.
module safe_cpu_reg_obi_responder
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned RSP_DEPTH = 2,
  parameter logic [31:0] ID_VALUE  = SAFE_REG_ID_VALUE
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  addr_i,
  input  logic [31:0]                  wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [31:0]                  rdata_o,
  output logic                         err_o,
  input  logic [31:0]                  hw_set_i,
  output logic [32*(NUM_REGS-2)-1:0]   ctrl_o,
  output logic                         irq_o
);

  localparam int unsigned NumCtrl   = NUM_REGS - SAFE_REG_CTRL_BASE;
  localparam logic [6:0]  NumRegsW  = 7'(NUM_REGS);
  localparam logic [5:0]  IdOff     = 6'(SAFE_REG_ID_OFFSET);
  localparam logic [5:0]  StatusOff = 6'(SAFE_REG_STATUS_OFFSET);

  logic [31:0]   status_q, status_d;
  logic [31:0]   ctrl_q [NumCtrl];
  logic [31:0]   ctrl_d [NumCtrl];
  logic          irq_q;

  logic [5:0]    word_off;
  logic [31:0]   be_mask;
  logic          acc_err;
  logic [31:0]   rd_val;
  logic          wr_ok;
  logic [31:0]   clr;

  logic          fifo_full, fifo_empty, pop;
  safe_reg_rsp_t rsp_in, rsp_out;

  // Address decode, error detection and read mux (pre-update values)
  always_comb begin
    word_off = addr_i[7:2];
    be_mask  = be_to_mask(be_i);
    acc_err  = (addr_i[1:0] != 2'b00) | ({1'b0, word_off} >= NumRegsW) |
               (we_i & (word_off == IdOff));
    rd_val   = '0;
    if (word_off == IdOff)     rd_val = ID_VALUE;
    if (word_off == StatusOff) rd_val = status_q;
    for (int i = 0; i < NumCtrl; i++) begin
      if (word_off == 6'(i + SAFE_REG_CTRL_BASE)) rd_val = ctrl_q[i];
    end
  end

  // Grant is blocked only by a full buffer, and held low during reset
  assign gnt_o = req_i & ~fifo_full & rst_ni;
  assign wr_ok = gnt_o & we_i & ~acc_err;
  assign pop   = rvalid_o & rready_i;

  // Response formed in the grant cycle
  always_comb begin
    rsp_in.err   = acc_err;
    rsp_in.rdata = acc_err ? ERR_RDATA : (we_i ? 32'h0 : rd_val);
  end

  // Register next-state; a hardware set beats a simultaneous W1C clear
  always_comb begin
    clr      = (wr_ok && (word_off == StatusOff)) ? (wdata_i & be_mask) : 32'h0;
    status_d = (status_q & ~clr) | hw_set_i;
    for (int i = 0; i < NumCtrl; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (wr_ok && (word_off == 6'(i + SAFE_REG_CTRL_BASE))) begin
        ctrl_d[i] = (ctrl_q[i] & ~be_mask) | (wdata_i & be_mask);
      end
    end
  end

  // Register bank and IRQ flop; irq tracks the status value being loaded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NumCtrl; i++) ctrl_q[i] <= '0;
    end else begin
      status_q <= status_d;
      irq_q    <= |status_d;
      for (int i = 0; i < NumCtrl; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  obi_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (safe_reg_rsp_t)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_o),
    .data_i  (rsp_in),
    .pop_i   (pop),
    .data_o  (rsp_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs; response fields forced to zero while no response is valid
  always_comb begin
    rvalid_o = ~fifo_empty;
    rdata_o  = rvalid_o ? rsp_out.rdata : 32'h0;
    err_o    = rvalid_o & rsp_out.err;
    irq_o    = irq_q;
    for (int i = 0; i < NumCtrl; i++) ctrl_o[32*i +: 32] = ctrl_q[i];
  end

endmodule
